qdec_cabac_bin_arb: RTL and testbench
=====================================

Name: qdec_cabac_bin_arb

Overview:
- Arbitrates the single shared CABAC bin-decoding engine (context memory plus arithmetic decoder) among the syntax sub-FSMs: CU, DQP, TU and residual.
- Each sub-FSM holds a request for the duration of its syntax element; the arbiter grants one requester at a time, round-robin.
- The granted requester's context address, run and EP-mode signals are muxed to the engine, and returned bins are routed back to that requester only.
- The grant is held until the requester releases it and all of its in-flight bins have returned.

Parameters:
- NUM_REQ, 4, number of sub-FSM requesters (index 0=CU, 1=DQP, 2=TU, 3=residual).
- CTX_AW, 10, context address width.
- MAX_OUTST, 4, maximum bins in flight between dec_run and ruiBin_vld.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req_i  in  NUM_REQ  per-requester request; held high while the sub-FSM is in its element.
- release_i  in  NUM_REQ  per-requester one-cycle pulse: element finished.
- ctx_addr_i  in  NUM_REQ*CTX_AW  packed per-requester context address.
- ctx_addr_vld_i  in  NUM_REQ  per-requester context address valid.
- dec_run_i  in  NUM_REQ  per-requester decode start.
- EPMode_i  in  NUM_REQ  per-requester bypass mode.
- grant_o  out  NUM_REQ  one-hot grant, registered.
- ctx_addr_o  out  CTX_AW  muxed context address to context memory.
- ctx_addr_vld_o  out  1  muxed context address valid.
- dec_run_o  out  1  muxed decode start to engine.
- EPMode_o  out  1  muxed bypass mode.
- dec_rdy  in  1  engine ready.
- ruiBin  in  1  decoded bin.
- ruiBin_vld  in  1  decoded bin valid.
- ruiBin_vld_o  out  NUM_REQ  bin valid routed to the granted/draining owner.
- ruiBin_o  out  1  ruiBin passed through.
- arb_err  out  1  sticky protocol error.

Behaviour:
- Reset:
  - state=IDLE_ARB, grant_o=0, rr_ptr=0, outst=0, arb_err=0.
  - All muxed outputs are 0 while grant_o=0.
- States: IDLE_ARB, GRANT_ARB, DRAIN_ARB.
- IDLE_ARB:
  - If any req_i is high, pick the first set bit searching from rr_ptr upward with wrap.
  - grant_o is registered next cycle; state goes to GRANT_ARB.
  - Request-to-grant latency is 1 cycle.
- GRANT_ARB:
  - Outputs are a combinational mux of the owner's inputs.
  - dec_run_o = dec_run_i[owner] & dec_rdy.
  - On release_i[owner]: if outst==0 (after this cycle's update), go to IDLE_ARB; else go to DRAIN_ARB.
- DRAIN_ARB:
  - ctx_addr_vld_o, dec_run_o and EPMode_o are forced to 0.
  - ruiBin_vld is still routed to the owner.
  - When outst reaches 0, go to IDLE_ARB.
- Leaving GRANT_ARB/DRAIN_ARB: grant_o cleared and rr_ptr = owner+1 mod NUM_REQ.
- Re-grant timing: the earliest re-grant is 1 cycle after returning to IDLE_ARB, so there is a minimum of 1 idle cycle between owners.
- Outstanding counter (outst, width clog2(MAX_OUTST)+1):
  - +1 on each forwarded dec_run_o; -1 on each ruiBin_vld.
  - Both in the same cycle: outst unchanged.
- ruiBin_vld_o = ruiBin_vld ? grant_o : 0. ruiBin_o = ruiBin.
- arb_err is set (sticky until reset) on any of the following:
  - ruiBin_vld with outst==0; the bin is dropped.
  - dec_run_i[owner] while dec_rdy=0; the run is dropped, not queued.
  - dec_run_i or ctx_addr_vld_i from a non-owner; ignored.
  - dec_run_i[owner] while outst==MAX_OUTST; dropped.
  - release_i from a non-owner; ignored.
- Simultaneous release_i[owner] and req_i[owner] high: the owner goes to lowest priority. It is re-granted only if no other requester is pending.
- req_i deasserted without release_i: the grant is held; release_i is the only end-of-element signal.
- Reset mid-operation: in-flight bins are abandoned. The engine is reset by the same rst_n.

Decomposition:
- Shared package qdec_cabac_package gets:
  - typedef t_state_arb {IDLE_ARB, GRANT_ARB, DRAIN_ARB}.
  - Localparam requester indices REQ_CU=0, REQ_DQP=1, REQ_TU=2, REQ_RES=3.
- One sub-module qdec_rr_pick: combinational round-robin picker.
  - Inputs: req vector and rr_ptr. Output: one-hot pick.
  - Reused for future SAO/merge requesters.

Test Plan:
- Single requester: req_i=0010, 3 runs, 3 bins, release.
  - grant_o=0010 one cycle after req.
  - ruiBin_vld_o[1] pulses 3 times.
  - IDLE_ARB 1 cycle after release; arb_err=0.
- Contention: req_i=1011 at once, grant 0 releases, then 1, then 3.
  - Grant order is 0,1,3; next owner after 3 is 0 (wrap).
- Drain: owner releases with outst=2, bins return 2 and 4 cycles later.
  - state=DRAIN_ARB, dec_run_o=0.
  - ruiBin_vld_o still goes to the owner.
  - IDLE_ARB the cycle after outst=0.
- Stall: dec_rdy=0 while dec_run_i[owner]=1.
  - dec_run_o=0, outst unchanged, arb_err=1.
- Non-owner traffic: dec_run_i[2]=1 while grant_o=0001.
  - dec_run_o=0, arb_err=1.
- Reset mid-drain: rst_n=0 for 1 cycle with outst=3.
  - grant_o=0, outst=0, state=IDLE_ARB, arb_err=0.

Source files
------------

// File: rtl/qdec_cabac_bin_arb_pkg.sv
// ---------------------------------------------------------------------------
// qdec_cabac_package
// Shared types and constants for the CABAC bin-engine arbiter and the
// syntax sub-FSMs that request the engine.
//   t_state_arb : arbiter FSM state encoding
//   REQ_*       : requester index of each syntax sub-FSM
// ---------------------------------------------------------------------------
package qdec_cabac_package;

    typedef enum logic [1:0] {
        IDLE_ARB  = 2'd0,
        GRANT_ARB = 2'd1,
        DRAIN_ARB = 2'd2
    } t_state_arb;

    localparam int REQ_CU  = 0;
    localparam int REQ_DQP = 1;
    localparam int REQ_TU  = 2;
    localparam int REQ_RES = 3;

endpackage

// File: rtl/qdec_cabac_bin_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// qdec_rr_pick
// Combinational round-robin picker: returns the first set request searching
// upward from rr_ptr_i, wrapping at NUM_REQ.
//   req_i    : request vector
//   rr_ptr_i : index of the highest-priority requester
//   pick_o   : one-hot pick, all zero when no request is set
// ---------------------------------------------------------------------------
module qdec_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   rr_ptr_i,
    output logic [NUM_REQ-1:0] pick_o
);

    always_comb begin
        logic             found;
        logic [PTR_W-1:0] idx;
        pick_o = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PTR_W'((int'(rr_ptr_i) + i) % NUM_REQ);
            if (!found && req_i[idx]) begin
                pick_o[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/qdec_cabac_bin_arb.sv
// ---------------------------------------------------------------------------
// qdec_cabac_bin_arb
// Round-robin arbiter sharing one CABAC bin-decoding engine among the syntax
// sub-FSMs (CU, DQP, TU, residual). The owner's context address / run / EP
// signals are muxed to the engine; returned bins are routed back to the
// owner. A grant is held until release_i and until every in-flight bin of the
// owner has returned.
//   clk, rst_n       : clock, synchronous active-low reset
//   req_i            : per-requester request (held for the element)
//   release_i        : per-requester end-of-element pulse
//   ctx_addr_i       : packed per-requester context addresses
//   ctx_addr_vld_i   : per-requester context address valid
//   dec_run_i        : per-requester decode start
//   EPMode_i         : per-requester bypass mode
//   grant_o          : registered one-hot grant
//   ctx_addr_o/_vld_o, dec_run_o, EPMode_o : muxed engine controls
//   dec_rdy          : engine ready
//   ruiBin, ruiBin_vld : engine bin result
//   ruiBin_vld_o     : bin valid routed to the owner
//   ruiBin_o         : bin value
//   arb_err          : sticky protocol error
// ---------------------------------------------------------------------------
module qdec_cabac_bin_arb
    import qdec_cabac_package::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int CTX_AW    = 10,
    parameter int MAX_OUTST = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        release_i,
    input  logic [NUM_REQ*CTX_AW-1:0] ctx_addr_i,
    input  logic [NUM_REQ-1:0]        ctx_addr_vld_i,
    input  logic [NUM_REQ-1:0]        dec_run_i,
    input  logic [NUM_REQ-1:0]        EPMode_i,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic [CTX_AW-1:0]         ctx_addr_o,
    output logic                      ctx_addr_vld_o,
    output logic                      dec_run_o,
    output logic                      EPMode_o,
    input  logic                      dec_rdy,
    input  logic                      ruiBin,
    input  logic                      ruiBin_vld,
    output logic [NUM_REQ-1:0]        ruiBin_vld_o,
    output logic                      ruiBin_o,
    output logic                      arb_err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int OW    = $clog2(MAX_OUTST) + 1;

    t_state_arb         state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [PTR_W-1:0]   rr_ptr_q;
    logic [OW-1:0]      outst_q;
    logic [OW-1:0]      outst_d;
    logic               arb_err_q;

    logic [NUM_REQ-1:0] pick;
    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   rr_next;
    logic [CTX_AW-1:0]  ctx_arr [NUM_REQ];
    logic               in_grant;
    logic               in_drain;
    logic               full;
    logic               empty;
    logic               own_run;
    logic               run_fwd;
    logic               bin_ok;
    logic               owner_rel;
    logic               err_set;

    qdec_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req_i    (req_i),
        .rr_ptr_i (rr_ptr_q),
        .pick_o   (pick)
    );

    always_comb begin
        owner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) owner = PTR_W'(i);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            ctx_arr[i] = ctx_addr_i[i*CTX_AW +: CTX_AW];
        end
    end

    always_comb begin
        in_grant  = (state_q == GRANT_ARB);
        in_drain  = (state_q == DRAIN_ARB);
        full      = (outst_q == OW'(MAX_OUTST));
        empty     = (outst_q == '0);
        own_run   = in_grant & dec_run_i[owner];
        // Runs are never queued: a stalled or over-limit run is simply lost.
        run_fwd   = own_run & dec_rdy & ~full;
        // A bin with nothing outstanding has no owner to go to.
        bin_ok    = ruiBin_vld & ~empty;
        owner_rel = in_grant & release_i[owner];
        rr_next   = PTR_W'((int'(owner) + 1) % NUM_REQ);
        outst_d   = outst_q + {{(OW-1){1'b0}}, run_fwd} - {{(OW-1){1'b0}}, bin_ok};

        // grant_q is zero in IDLE, so any traffic there counts as non-owner.
        err_set   = (ruiBin_vld & empty)
                  | (own_run & ~dec_rdy)
                  | (own_run & full)
                  | (|((dec_run_i | ctx_addr_vld_i | release_i) & ~grant_q));

        ctx_addr_o     = in_grant ? ctx_arr[owner] : '0;
        ctx_addr_vld_o = in_grant & ctx_addr_vld_i[owner];
        EPMode_o       = in_grant & EPMode_i[owner];
        dec_run_o      = run_fwd;
        ruiBin_vld_o   = bin_ok ? grant_q : '0;
        ruiBin_o       = ruiBin;
        grant_o        = grant_q;
        arb_err        = arb_err_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE_ARB;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            outst_q   <= '0;
            arb_err_q <= 1'b0;
        end else begin
            outst_q <= outst_d;
            if (err_set) arb_err_q <= 1'b1;
            case (state_q)
                IDLE_ARB: begin
                    if (|req_i) begin
                        grant_q <= pick;
                        state_q <= GRANT_ARB;
                    end
                end
                GRANT_ARB: begin
                    if (owner_rel) begin
                        if (outst_d == '0) begin
                            grant_q  <= '0;
                            rr_ptr_q <= rr_next;
                            state_q  <= IDLE_ARB;
                        end else begin
                            state_q  <= DRAIN_ARB;
                        end
                    end
                end
                DRAIN_ARB: begin
                    if (outst_d == '0) begin
                        grant_q  <= '0;
                        rr_ptr_q <= rr_next;
                        state_q  <= IDLE_ARB;
                    end
                end
                default: begin
                    grant_q <= '0;
                    state_q <= IDLE_ARB;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qdec_cabac_bin_arb.sv
module tb_qdec_cabac_bin_arb;
    import qdec_cabac_package::*;

    localparam int NUM_REQ = 4;
    localparam int CTX_AW  = 10;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_i;
    logic [NUM_REQ-1:0]        release_i;
    logic [NUM_REQ*CTX_AW-1:0] ctx_addr_i;
    logic [NUM_REQ-1:0]        ctx_addr_vld_i;
    logic [NUM_REQ-1:0]        dec_run_i;
    logic [NUM_REQ-1:0]        EPMode_i;
    logic [NUM_REQ-1:0]        grant_o;
    logic [CTX_AW-1:0]         ctx_addr_o;
    logic                      ctx_addr_vld_o;
    logic                      dec_run_o;
    logic                      EPMode_o;
    logic                      dec_rdy;
    logic                      ruiBin;
    logic                      ruiBin_vld;
    logic [NUM_REQ-1:0]        ruiBin_vld_o;
    logic                      ruiBin_o;
    logic                      arb_err;

    int tests = 0;
    int fails = 0;

    logic [NUM_REQ-1:0] exp_grant [$];
    logic [NUM_REQ:0]   exp_bin   [$];
    logic [NUM_REQ-1:0] prev_grant = '0;

    always #5 clk = ~clk;

    qdec_cabac_bin_arb #(.NUM_REQ(NUM_REQ), .CTX_AW(CTX_AW), .MAX_OUTST(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_i          (req_i),
        .release_i      (release_i),
        .ctx_addr_i     (ctx_addr_i),
        .ctx_addr_vld_i (ctx_addr_vld_i),
        .dec_run_i      (dec_run_i),
        .EPMode_i       (EPMode_i),
        .grant_o        (grant_o),
        .ctx_addr_o     (ctx_addr_o),
        .ctx_addr_vld_o (ctx_addr_vld_o),
        .dec_run_o      (dec_run_o),
        .EPMode_o       (EPMode_o),
        .dec_rdy        (dec_rdy),
        .ruiBin         (ruiBin),
        .ruiBin_vld     (ruiBin_vld),
        .ruiBin_vld_o   (ruiBin_vld_o),
        .ruiBin_o       (ruiBin_o),
        .arb_err        (arb_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_i          = '0;
        release_i      = '0;
        ctx_addr_i     = '0;
        ctx_addr_vld_i = '0;
        dec_run_i      = '0;
        EPMode_i       = '0;
        dec_rdy        = 1'b1;
        ruiBin         = 1'b0;
        ruiBin_vld     = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic send_bin(input logic [NUM_REQ-1:0] owner_exp, input logic b);
        ruiBin_vld = 1'b1;
        ruiBin     = b;
        exp_bin.push_back({owner_exp, b});
        tick();
        ruiBin_vld = 1'b0;
    endtask

    // Monitor: pops expectations whenever the DUT presents a new grant or a routed bin.
    always @(negedge clk) begin
        if (grant_o !== prev_grant && grant_o !== '0) begin
            if (exp_grant.size() == 0) check("grant_unexpected", 32'(grant_o), 32'd0);
            else check("grant_order", 32'(grant_o), 32'(exp_grant.pop_front()));
        end
        prev_grant <= grant_o;
        if (rst_n && ruiBin_vld_o !== '0) begin
            if (exp_bin.size() == 0) check("bin_unexpected", 32'(ruiBin_vld_o), 32'd0);
            else check("bin_route", 32'({ruiBin_vld_o, ruiBin_o}), 32'(exp_bin.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] bits;
        do_reset();
        #1;
        check("rst_grant", 32'(grant_o), 32'd0);
        check("rst_err", 32'(arb_err), 32'd0);
        check("rst_run", 32'(dec_run_o), 32'd0);
        check("rst_ctx_vld", 32'(ctx_addr_vld_o), 32'd0);
        check("rst_ctx_addr", 32'(ctx_addr_o), 32'd0);

        // Single requester (DQP)
        req_i = 4'b0010;
        exp_grant.push_back(4'b0010);
        tick();
        check("s1_grant_lat", 32'(grant_o), 32'h2);
        ctx_addr_i[REQ_DQP*CTX_AW +: CTX_AW] = 10'h155;
        ctx_addr_vld_i[REQ_DQP] = 1'b1;
        EPMode_i[REQ_DQP]       = 1'b1;
        dec_run_i[REQ_DQP]      = 1'b1;
        #1;
        check("s1_ctx_addr", 32'(ctx_addr_o), 32'h155);
        check("s1_ctx_vld", 32'(ctx_addr_vld_o), 32'd1);
        check("s1_ep", 32'(EPMode_o), 32'd1);
        check("s1_run", 32'(dec_run_o), 32'd1);
        tick(); tick(); tick();
        dec_run_i = '0; ctx_addr_vld_i = '0; EPMode_i = '0;
        bits = 3'b101;
        for (int i = 0; i < 3; i++) send_bin(4'b0010, bits[i]);
        release_i[REQ_DQP] = 1'b1;
        req_i = '0;
        tick();
        release_i = '0;
        check("s1_idle_after_rel", 32'(grant_o), 32'd0);
        check("s1_err", 32'(arb_err), 32'd0);

        // Contention: 0,1,3 then wrap to 0; releasing owner with req held goes last
        do_reset();
        req_i = 4'b1011;
        exp_grant.push_back(4'b0001);
        tick();
        check("s2_grant0", 32'(grant_o), 32'h1);
        release_i = 4'b0001; req_i = 4'b1010;
        tick();
        release_i = '0;
        check("s2_gap0", 32'(grant_o), 32'd0);
        exp_grant.push_back(4'b0010);
        tick();
        check("s2_grant1", 32'(grant_o), 32'h2);
        release_i = 4'b0010; req_i = 4'b1000;
        tick();
        release_i = '0;
        check("s2_gap1", 32'(grant_o), 32'd0);
        exp_grant.push_back(4'b1000);
        tick();
        check("s2_grant3", 32'(grant_o), 32'h8);
        release_i = 4'b1000; req_i = 4'b1001;
        tick();
        release_i = '0;
        check("s2_gap3", 32'(grant_o), 32'd0);
        exp_grant.push_back(4'b0001);
        tick();
        check("s2_wrap0", 32'(grant_o), 32'h1);
        release_i = 4'b0001; req_i = 4'b1000;
        tick();
        release_i = '0;
        exp_grant.push_back(4'b1000);
        tick();
        check("s2_regrant3", 32'(grant_o), 32'h8);
        release_i = 4'b1000; req_i = '0;
        tick();
        release_i = '0;
        check("s2_err", 32'(arb_err), 32'd0);

        // Drain: TU releases with 2 bins outstanding
        do_reset();
        req_i = 4'b0100;
        exp_grant.push_back(4'b0100);
        tick();
        dec_run_i[REQ_TU] = 1'b1;
        tick(); tick();
        dec_run_i = '0;
        release_i[REQ_TU] = 1'b1; req_i = '0;
        tick();
        release_i = '0;
        check("s3_drain_hold", 32'(grant_o), 32'h4);
        dec_run_i[REQ_TU] = 1'b1; ctx_addr_vld_i[REQ_TU] = 1'b1; EPMode_i[REQ_TU] = 1'b1;
        #1;
        check("s3_drain_run", 32'(dec_run_o), 32'd0);
        check("s3_drain_ctx_vld", 32'(ctx_addr_vld_o), 32'd0);
        check("s3_drain_ep", 32'(EPMode_o), 32'd0);
        dec_run_i = '0; ctx_addr_vld_i = '0; EPMode_i = '0;
        tick();
        send_bin(4'b0100, 1'b1);
        tick();
        check("s3_drain_hold2", 32'(grant_o), 32'h4);
        send_bin(4'b0100, 1'b0);
        check("s3_idle", 32'(grant_o), 32'd0);

        // Stall and outstanding limit on CU
        do_reset();
        req_i = 4'b0001;
        exp_grant.push_back(4'b0001);
        tick();
        dec_rdy = 1'b0; dec_run_i[REQ_CU] = 1'b1;
        #1;
        check("s4_stall_run", 32'(dec_run_o), 32'd0);
        tick();
        dec_run_i = '0; dec_rdy = 1'b1;
        check("s4_stall_err", 32'(arb_err), 32'd1);
        dec_run_i[REQ_CU] = 1'b1;
        tick(); tick(); tick(); tick();
        #1;
        check("s4_full_run", 32'(dec_run_o), 32'd0);
        tick();
        dec_run_i = '0;
        bits = 3'b110;
        for (int i = 0; i < 3; i++) send_bin(4'b0001, bits[i]);
        send_bin(4'b0001, 1'b1);
        release_i[REQ_CU] = 1'b1; req_i = '0;
        tick();
        release_i = '0;
        check("s4_idle_outst0", 32'(grant_o), 32'd0);

        // Non-owner traffic
        do_reset();
        req_i = 4'b0001;
        exp_grant.push_back(4'b0001);
        tick();
        dec_run_i[REQ_TU] = 1'b1;
        #1;
        check("s5_nonowner_run", 32'(dec_run_o), 32'd0);
        tick();
        dec_run_i = '0;
        check("s5_nonowner_err", 32'(arb_err), 32'd1);
        release_i[REQ_CU] = 1'b1; req_i = '0;
        tick();
        release_i = '0;

        // Reset mid-drain with 3 bins outstanding
        do_reset();
        req_i = 4'b1000;
        exp_grant.push_back(4'b1000);
        tick();
        dec_run_i[REQ_RES] = 1'b1;
        tick(); tick(); tick();
        dec_run_i = '0;
        release_i[REQ_RES] = 1'b1; req_i = '0;
        tick();
        release_i = '0;
        check("s6_drain", 32'(grant_o), 32'h8);
        dec_run_i[REQ_CU] = 1'b1;
        tick();
        dec_run_i = '0;
        check("s6_err_pre", 32'(arb_err), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("s6_rst_grant", 32'(grant_o), 32'd0);
        check("s6_rst_err", 32'(arb_err), 32'd0);
        req_i = 4'b1000;
        exp_grant.push_back(4'b1000);
        tick();
        release_i[REQ_RES] = 1'b1; req_i = '0;
        tick();
        release_i = '0;
        check("s6_outst_cleared", 32'(grant_o), 32'd0);
        check("s6_err_final", 32'(arb_err), 32'd0);

        tick(); tick();
        check("grant_queue_empty", 32'(exp_grant.size()), 32'd0);
        check("bin_queue_empty", 32'(exp_bin.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
